// File: rtl/ts_tag_pkg.sv
// Shared constants and types for the PKTE timestamp tag parser.
// Tag positions are byte indices from the first marker byte.
package ts_tag_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_MARK,
      ST_FIELDS,
      ST_TAIL
   } state_e;

   localparam int TAG_LEN = 19;

   localparam logic [7:0] MARK0 = 8'h50;
   localparam logic [7:0] MARK1 = 8'h4B;
   localparam logic [7:0] MARK2 = 8'h54;
   localparam logic [7:0] MARK3 = 8'h45;

   localparam logic [4:0] PORT  = 5'd4;
   localparam logic [4:0] FLAG0 = 5'd5;
   localparam logic [4:0] FLAG1 = 5'd6;
   localparam logic [4:0] SEC0  = 5'd9;
   localparam logic [4:0] NS0   = 5'd13;
   localparam logic [4:0] LEN0  = 5'd17;
   localparam logic [4:0] LAST  = 5'(TAG_LEN - 1);

   function automatic logic [7:0] marker_byte(input logic [1:0] i);
      logic [7:0] m;
      unique case (i)
         2'd0:    m = MARK0;
         2'd1:    m = MARK1;
         2'd2:    m = MARK2;
         default: m = MARK3;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ts_tag_parser_sat_counter.sv
// Saturating up-counter for tag statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/ts_tag_parser.sv
// Locates the PKTE timestamp tag after TAG_OFFSET frame bytes, unpacks it
// and forwards the frame one cycle later with the tag bytes removed.
module ts_tag_parser
   import ts_tag_pkg::*;
#(
   parameter int TAG_OFFSET = 12,
   parameter int CNT_W      = 16
) (
   input  logic             rxc,
   input  logic             RST,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic             in_eof,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_sof,
   output logic             out_eof,
   output logic             tag_valid,
   output logic             tag_err,
   output logic [7:0]       tag_port,
   output logic             tag_crc_wrong,
   output logic             tag_len_long,
   output logic             tag_len_short,
   output logic [31:0]      tag_sec,
   output logic [31:0]      tag_ns,
   output logic [10:0]      tag_len,
   output logic [CNT_W-1:0] tag_ok_cnt,
   output logic [CNT_W-1:0] tag_bad_cnt
);

   localparam logic [4:0] PRE_LAST =
      (TAG_OFFSET == 0) ? 5'd0 : 5'(TAG_OFFSET - 1);

   state_e     state_q, state_d;
   state_e     cur_st;
   logic [4:0] cnt_q, cnt_d;
   logic [4:0] idx;
   logic [4:0] pos;
   logic       start;
   logic       abort;
   logic       fwd;
   logic       good;
   logic       err;
   logic       cap;

   logic [7:0]  port_s_q;
   logic        crc_s_q;
   logic        long_s_q;
   logic        short_s_q;
   logic [31:0] sec_s_q;
   logic [31:0] ns_s_q;
   logic [7:0]  len_s_q;

   logic [7:0]  out_data_q;
   logic        out_valid_q;
   logic        out_sof_q;
   logic        out_eof_q;
   logic        tag_valid_q;
   logic        tag_err_q;
   logic [7:0]  tag_port_q;
   logic        tag_crc_q;
   logic        tag_long_q;
   logic        tag_short_q;
   logic [31:0] tag_sec_q;
   logic [31:0] tag_ns_q;
   logic [10:0] tag_len_q;

   // A new sof restarts parsing from the sof byte itself, whatever state
   // the previous frame was left in.
   always_comb begin
      start   = in_valid & in_sof;
      abort   = start & (state_q != ST_IDLE);
      cur_st  = state_q;
      idx     = cnt_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      fwd     = 1'b0;
      good    = 1'b0;
      err     = 1'b0;
      cap     = 1'b0;
      if (start) begin
         cur_st = (TAG_OFFSET == 0) ? ST_MARK : ST_PRE;
         idx    = '0;
         err    = (state_q == ST_MARK) || (state_q == ST_FIELDS);
      end
      pos = (cur_st == ST_FIELDS) ? idx + PORT : idx;
      if (in_valid) begin
         state_d = cur_st;
         cnt_d   = idx;
         unique case (cur_st)
            ST_PRE: begin
               fwd = 1'b1;
               if (in_eof) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (idx == PRE_LAST) begin
                  state_d = ST_MARK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = idx + 5'd1;
               end
            end
            ST_MARK: begin
               if (in_eof) begin
                  fwd     = 1'b1;
                  err     = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (in_data != marker_byte(idx[1:0])) begin
                  err     = 1'b1;
                  state_d = ST_TAIL;
                  cnt_d   = '0;
               end else if (idx == 5'd3) begin
                  state_d = ST_FIELDS;
                  cnt_d   = '0;
               end else begin
                  cnt_d = idx + 5'd1;
               end
            end
            ST_FIELDS: begin
               if (in_eof) begin
                  fwd     = 1'b1;
                  err     = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (pos == LAST) begin
                  good    = 1'b1;
                  state_d = ST_TAIL;
                  cnt_d   = '0;
               end else begin
                  cap   = 1'b1;
                  cnt_d = idx + 5'd1;
               end
            end
            ST_TAIL: begin
               fwd = 1'b1;
               if (in_eof) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               fwd = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge rxc or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge rxc or negedge RST) begin
      if (!RST) begin
         port_s_q  <= '0;
         crc_s_q   <= 1'b0;
         long_s_q  <= 1'b0;
         short_s_q <= 1'b0;
         sec_s_q   <= '0;
         ns_s_q    <= '0;
         len_s_q   <= '0;
      end else if (cap) begin
         unique case (1'b1)
            (pos == PORT): port_s_q <= in_data;
            (pos == FLAG0): begin
               crc_s_q  <= in_data[4];
               long_s_q <= in_data[0];
            end
            (pos == FLAG1): short_s_q <= in_data[4];
            (pos >= SEC0 && pos < NS0):
               sec_s_q <= {in_data, sec_s_q[31:8]};
            (pos >= NS0 && pos < LEN0):
               ns_s_q <= {in_data, ns_s_q[31:8]};
            (pos == LEN0): len_s_q <= in_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge rxc or negedge RST) begin
      if (!RST) begin
         tag_valid_q <= 1'b0;
         tag_err_q   <= 1'b0;
         tag_port_q  <= '0;
         tag_crc_q   <= 1'b0;
         tag_long_q  <= 1'b0;
         tag_short_q <= 1'b0;
         tag_sec_q   <= '0;
         tag_ns_q    <= '0;
         tag_len_q   <= '0;
      end else begin
         tag_valid_q <= good;
         tag_err_q   <= err;
         if (good) begin
            tag_port_q  <= port_s_q;
            tag_crc_q   <= crc_s_q;
            tag_long_q  <= long_s_q;
            tag_short_q <= short_s_q;
            tag_sec_q   <= sec_s_q;
            tag_ns_q    <= ns_s_q;
            tag_len_q   <= {in_data[2:0], len_s_q};
         end
      end
   end

   always_ff @(posedge rxc or negedge RST) begin
      if (!RST) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         out_valid_q <= in_valid & fwd;
         out_sof_q   <= in_valid & fwd & in_sof;
         out_eof_q   <= in_valid & fwd & in_eof;
         if (in_valid) begin
            out_data_q <= in_data;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
      .clk_i   (rxc),
      .rst_ni  (RST),
      .inc_i   (tag_valid_q),
      .count_o (tag_ok_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
      .clk_i   (rxc),
      .rst_ni  (RST),
      .inc_i   (tag_err_q),
      .count_o (tag_bad_cnt)
   );

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   // The byte already on the output closes the aborted frame.
   assign out_eof   = out_eof_q | (abort & out_valid_q);

   assign tag_valid     = tag_valid_q;
   assign tag_err       = tag_err_q;
   assign tag_port      = tag_port_q;
   assign tag_crc_wrong = tag_crc_q;
   assign tag_len_long  = tag_long_q;
   assign tag_len_short = tag_short_q;
   assign tag_sec       = tag_sec_q;
   assign tag_ns        = tag_ns_q;
   assign tag_len       = tag_len_q;

endmodule

// File: tb/tb_ts_tag_parser.sv
// Bench for ts_tag_parser: table vectors, abort/reset sequences and random
// frames against a frame-level model of tag stripping and parsing.
module tb_ts_tag_parser;

   localparam int OFF = 12;

   typedef logic [7:0] bq_t[$];

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
   } fwd_t;

   typedef struct packed {
      logic [7:0]  port;
      logic        crc;
      logic        lng;
      logic        sht;
      logic [31:0] sec;
      logic [31:0] ns;
      logic [10:0] len;
   } tag_t;

   typedef struct {
      int len;
      int badk;
      int gap;
      bit plan;
      int exp_fwd;
      int exp_v;
      int exp_e;
   } vec_t;

   logic        rxc = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_eof = 1'b0;

   logic [7:0]  out_data;
   logic        out_valid, out_sof, out_eof;
   logic        tag_valid, tag_err;
   logic [7:0]  tag_port;
   logic        tag_crc_wrong, tag_len_long, tag_len_short;
   logic [31:0] tag_sec, tag_ns;
   logic [10:0] tag_len;
   logic [15:0] tag_ok_cnt, tag_bad_cnt;

   logic [7:0]  s_out_data;
   logic        s_out_valid, s_out_sof, s_out_eof;
   logic        s_tag_valid, s_tag_err;
   logic [7:0]  s_tag_port;
   logic        s_tag_crc_wrong, s_tag_len_long, s_tag_len_short;
   logic [31:0] s_tag_sec, s_tag_ns;
   logic [10:0] s_tag_len;
   logic [3:0]  s_tag_ok_cnt, s_tag_bad_cnt;

   ts_tag_parser #(.TAG_OFFSET(OFF), .CNT_W(16)) dut (
      .rxc(rxc), .RST(RST),
      .in_data(in_data), .in_valid(in_valid),
      .in_sof(in_sof), .in_eof(in_eof),
      .out_data(out_data), .out_valid(out_valid),
      .out_sof(out_sof), .out_eof(out_eof),
      .tag_valid(tag_valid), .tag_err(tag_err),
      .tag_port(tag_port), .tag_crc_wrong(tag_crc_wrong),
      .tag_len_long(tag_len_long), .tag_len_short(tag_len_short),
      .tag_sec(tag_sec), .tag_ns(tag_ns), .tag_len(tag_len),
      .tag_ok_cnt(tag_ok_cnt), .tag_bad_cnt(tag_bad_cnt)
   );

   ts_tag_parser #(.TAG_OFFSET(OFF), .CNT_W(4)) dut_s (
      .rxc(rxc), .RST(RST),
      .in_data(in_data), .in_valid(in_valid),
      .in_sof(in_sof), .in_eof(in_eof),
      .out_data(s_out_data), .out_valid(s_out_valid),
      .out_sof(s_out_sof), .out_eof(s_out_eof),
      .tag_valid(s_tag_valid), .tag_err(s_tag_err),
      .tag_port(s_tag_port), .tag_crc_wrong(s_tag_crc_wrong),
      .tag_len_long(s_tag_len_long), .tag_len_short(s_tag_len_short),
      .tag_sec(s_tag_sec), .tag_ns(s_tag_ns), .tag_len(s_tag_len),
      .tag_ok_cnt(s_tag_ok_cnt), .tag_bad_cnt(s_tag_bad_cnt)
   );

   always #5 rxc = ~rxc;

   fwd_t exp_q[$];
   fwd_t got_q[$];
   bq_t  frm, fa, fb;
   tag_t exp_tag = '0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mon_valid = 0;
   int   mon_err = 0;
   int   m_valid = 0;
   int   m_err = 0;
   int   okc = 0;
   int   badc = 0;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   always @(negedge rxc) begin
      #2;
      if (out_valid === 1'b1) got_q.push_back({out_data, out_sof, out_eof});
      if (tag_valid === 1'b1) mon_valid++;
      if (tag_err === 1'b1) mon_err++;
      if (tag_valid === 1'b1 || tag_err === 1'b1)
         chk("valid_err_excl", 64'(tag_valid & tag_err), 64'd0);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic void build(input int len, input int badk,
                                 input bit plan);
      logic [7:0]  img[19];
      logic [31:0] sec, ns;
      logic [10:0] ln;
      img[0] = 8'h50; img[1] = 8'h4B; img[2] = 8'h54; img[3] = 8'h45;
      if (plan) begin
         sec = 32'h12345678; ns = 32'h3B9AC9F0; ln = 11'h5DC;
         img[4] = 8'h00; img[5] = 8'h10; img[6] = 8'h00;
         img[7] = 8'h00; img[8] = 8'h00;
         img[18] = 8'h05;
      end else begin
         sec = $urandom; ns = $urandom; ln = 11'($urandom);
         for (int k = 4; k <= 8; k++) img[k] = 8'($urandom);
         img[18] = {5'($urandom), ln[10:8]};
      end
      for (int k = 0; k < 4; k++) begin
         img[9 + k]  = sec[8*k +: 8];
         img[13 + k] = ns[8*k +: 8];
      end
      img[17] = ln[7:0];
      if (badk >= 0)
         img[badk] = img[badk] ^ (plan ? 8'h01 : 8'($urandom_range(1, 255)));
      frm.delete();
      for (int i = 0; i < len; i++)
         frm.push_back((i >= OFF && i < OFF + 19) ? img[i - OFF]
                                                   : 8'($urandom));
   endfunction

   // Frame-level rules: marker/field bytes vanish, an eof inside the tag
   // is forwarded as truncation, an abort closes the last forwarded byte.
   task automatic model(input bq_t b, input bit aborted);
      logic [7:0] mk[4];
      bit drop[];
      int n, last;
      bit good, mism, trunc, err;
      fwd_t f;
      mk[0] = 8'h50; mk[1] = 8'h4B; mk[2] = 8'h54; mk[3] = 8'h45;
      n = b.size();
      drop = new[n];
      good = 0; mism = 0; trunc = 0;
      for (int k = 0; k < 19; k++) begin
         int p;
         p = OFF + k;
         if (p >= n) break;
         if (p == n - 1 && !aborted) begin trunc = 1; break; end
         drop[p] = 1;
         if (k < 4 && b[p] != mk[k]) begin mism = 1; break; end
         if (k == 18) good = 1;
      end
      err = trunc | mism | (aborted && n > OFF && !good && !mism);
      last = -1;
      for (int i = 0; i < n; i++) begin
         if (!drop[i]) begin
            exp_q.push_back({b[i], i == 0, (i == n - 1) && !aborted});
            last = i;
         end
      end
      if (aborted && last == n - 1) begin
         f = exp_q.pop_back();
         f.e = 1'b1;
         exp_q.push_back(f);
      end
      if (good) begin
         exp_tag.port = b[OFF + 4];
         exp_tag.crc  = b[OFF + 5][4];
         exp_tag.lng  = b[OFF + 5][0];
         exp_tag.sht  = b[OFF + 6][4];
         exp_tag.sec  = {b[OFF + 12], b[OFF + 11], b[OFF + 10], b[OFF + 9]};
         exp_tag.ns   = {b[OFF + 16], b[OFF + 15], b[OFF + 14], b[OFF + 13]};
         exp_tag.len  = {b[OFF + 18][2:0], b[OFF + 17]};
      end
      m_valid += int'(good);
      m_err   += int'(err);
      okc     += int'(good);
      badc    += int'(err);
   endtask

   task automatic drive(input bq_t b, input int nb, input bit eof_end,
                        input int gap);
      for (int i = 0; i < nb; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) begin
            @(negedge rxc);
            in_valid = 0; in_sof = 0; in_eof = 0; in_data = 8'($urandom);
         end
         @(negedge rxc);
         in_valid = 1;
         in_data  = b[i];
         in_sof   = (i == 0);
         in_eof   = eof_end && (i == b.size() - 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge rxc);
         in_valid = 0; in_sof = 0; in_eof = 0; in_data = 8'($urandom);
      end
   endtask

   task automatic clear_obs();
      got_q.delete(); exp_q.delete();
      mon_valid = 0; mon_err = 0; m_valid = 0; m_err = 0;
   endtask

   task automatic check_frame(input string nm, input int t_fwd,
                              input int t_v, input int t_e);
      int same;
      if (t_fwd >= 0) begin
         chk({nm, ".fwd_n"}, 64'(got_q.size()), 64'(t_fwd));
         chk({nm, ".valid_n"}, 64'(mon_valid), 64'(t_v));
         chk({nm, ".err_n"}, 64'(mon_err), 64'(t_e));
      end else begin
         chk({nm, ".fwd_n"}, 64'(got_q.size()), 64'(exp_q.size()));
         chk({nm, ".valid_n"}, 64'(mon_valid), 64'(m_valid));
         chk({nm, ".err_n"}, 64'(mon_err), 64'(m_err));
      end
      same = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] === exp_q[i]) same++;
      chk({nm, ".bytes_ok"}, 64'(same), 64'(exp_q.size()));
      chk({nm, ".sec"}, 64'(tag_sec), 64'(exp_tag.sec));
      chk({nm, ".ns"}, 64'(tag_ns), 64'(exp_tag.ns));
      chk({nm, ".misc"},
          64'({tag_port, tag_crc_wrong, tag_len_long, tag_len_short, tag_len}),
          64'({exp_tag.port, exp_tag.crc, exp_tag.lng, exp_tag.sht,
               exp_tag.len}));
      chk({nm, ".ok_cnt"}, 64'(tag_ok_cnt), 64'(okc > 65535 ? 65535 : okc));
      chk({nm, ".bad_cnt"}, 64'(tag_bad_cnt), 64'(badc > 65535 ? 65535 : badc));
      chk({nm, ".s_ok_cnt"}, 64'(s_tag_ok_cnt), 64'(okc > 15 ? 15 : okc));
      chk({nm, ".s_bad_cnt"}, 64'(s_tag_bad_cnt), 64'(badc > 15 ? 15 : badc));
      clear_obs();
   endtask

   initial begin
      vt.push_back('{80, -1,  0, 1, 61, 1, 0});
      vt.push_back('{80,  2,  0, 1, 77, 0, 1});
      vt.push_back('{23, -1,  0, 0, 13, 0, 1});
      vt.push_back('{80, -1, 50, 1, 61, 1, 0});
      vt.push_back('{10, -1,  0, 0, 10, 0, 0});
      vt.push_back('{12, -1,  0, 0, 12, 0, 0});
      vt.push_back('{13, -1,  0, 0, 13, 0, 1});
      vt.push_back('{31, -1,  0, 0, 13, 0, 1});
      vt.push_back('{32, -1,  0, 0, 13, 1, 0});
      vt.push_back('{80,  0,  0, 0, 79, 0, 1});
      vt.push_back('{80,  3, 30, 0, 76, 0, 1});
      vt.push_back('{64, -1, 20, 0, 45, 1, 0});

      #1 RST = 0;
      repeat (3) @(negedge rxc);
      #2;
      chk("reset.out", 64'({out_valid, out_sof, out_eof, out_data}), 64'd0);
      chk("reset.pulse", 64'({tag_valid, tag_err}), 64'd0);
      chk("reset.tag", 64'({tag_port, tag_sec, tag_len}), 64'd0);
      chk("reset.cnt", 64'({tag_ok_cnt, tag_bad_cnt}), 64'd0);
      @(negedge rxc);
      RST = 1;
      idle(2);
      clear_obs();

      foreach (vt[i]) begin
         build(vt[i].len, vt[i].badk, vt[i].plan);
         model(frm, 0);
         drive(frm, frm.size(), 1, vt[i].gap);
         idle(5);
         if (i == 0) begin
            chk("plan.sec", 64'(tag_sec), 64'h12345678);
            chk("plan.ns", 64'(tag_ns), 64'h3B9AC9F0);
            chk("plan.len", 64'(tag_len), 64'd1500);
            chk("plan.crc", 64'(tag_crc_wrong), 64'd1);
            chk("plan.ok_cnt", 64'(tag_ok_cnt), 64'd1);
         end
         check_frame($sformatf("vec%0d", i), vt[i].exp_fwd,
                     vt[i].exp_v, vt[i].exp_e);
      end

      // Aborts in TAIL, FIELDS and PRE, each followed by a clean frame.
      foreach (vt[i]) begin
         int la;
         if (i >= 3) break;
         la = (i == 0) ? 40 : (i == 1) ? 20 : 6;
         build(la, -1, 0); fa = frm;
         build(50, -1, 0); fb = frm;
         model(fa, 1);
         model(fb, 0);
         drive(fa, fa.size(), 0, 0);
         drive(fb, fb.size(), 1, 0);
         idle(5);
         check_frame($sformatf("abort%0d", i), -1, 0, 0);
      end

      for (int r = 0; r < 30; r++) begin
         int badk;
         badk = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
         build(int'($urandom_range(8, 100)), badk, 0);
         model(frm, 0);
         drive(frm, frm.size(), 1, $urandom_range(1) ? 0 : 40);
         idle(5);
         check_frame($sformatf("rnd%0d", r), -1, 0, 0);
      end

      build(60, -1, 0);
      drive(frm, 20, 1, 0);
      @(posedge rxc);
      #1 RST = 0;
      #1;
      chk("midrst.out", 64'({out_valid, out_sof, out_eof, out_data}), 64'd0);
      chk("midrst.pulse", 64'({tag_valid, tag_err}), 64'd0);
      chk("midrst.tag", 64'({tag_port, tag_crc_wrong, tag_len}), 64'd0);
      chk("midrst.secns", {tag_sec, tag_ns}, 64'd0);
      chk("midrst.cnt", 64'({tag_ok_cnt, tag_bad_cnt}), 64'd0);
      idle(2);
      RST = 1;
      idle(2);
      clear_obs();
      okc = 0; badc = 0; exp_tag = '0;
      build(60, -1, 0);
      model(frm, 0);
      drive(frm, frm.size(), 1, 0);
      idle(5);
      chk("midrst.next_ok", 64'(tag_ok_cnt), 64'd1);
      check_frame("midrst.next", -1, 0, 0);

      for (int s = 0; s < 19; s++) begin
         build(30, 0, 0);
         model(frm, 0);
         drive(frm, frm.size(), 1, 0);
         idle(4);
         check_frame($sformatf("sat%0d", s), -1, 0, 0);
      end
      chk("sat.small_bad", 64'(s_tag_bad_cnt), 64'd15);
      chk("sat.big_bad", 64'(tag_bad_cnt), 64'd19);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
